dla_reset_sequencer: RTL
========================

DLA_RESET_SEQUENCER -- requirements
Module: dla_reset_sequencer

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: reset domains driven; legal 1..16.
REQ-002 Parameter META_STAGES, default 3: synchronizer depth; legal >=2.
REQ-003 Parameter PIPE_STAGES, default 2: retiming pipeline on each output; legal >=0.
REQ-004 Parameter MIN_ASSERT_CYCLES, default 16: minimum cycles all channels are held in reset after internal reset deasserts; legal >=1.
REQ-005 Parameter RELEASE_GAP, default 8: cycles between consecutive channel releases; legal >=1.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 i_async_reset  input  1  reset is asynchronous and active-high.
REQ-008 i_soft_reset_req  input  1  synchronous single-cycle soft-reset request.
REQ-009 o_soft_reset_ack  output  1  one-cycle pulse on completion of a soft-reset sequence.
REQ-010 o_async_resetn  output  NUM_CHANNELS  per channel: async assert, sync deassert, active-low.
REQ-011 o_sync_resetn  output  NUM_CHANNELS  per channel: sync assert, sync deassert, active-low.
REQ-012 o_reset_done  output  1  high when every channel is released.

Function
REQ-013 Internal reset r_int_reset SHALL assert asynchronously with i_async_reset and deassert META_STAGES rising edges after i_async_reset falls.
REQ-014 FSM states SHALL be HOLD, RELEASE, RUN, SOFT; r_int_reset forces HOLD.
REQ-015 HOLD: counter counts MIN_ASSERT_CYCLES, then moves to RELEASE with channel index 0.
REQ-016 RELEASE: release vector bit k sets on entry plus k*RELEASE_GAP cycles; after bit NUM_CHANNELS-1 sets, move to RUN.
REQ-017 Release vector SHALL release channels in ascending index order, never more than one per cycle; bits stay set until HOLD or SOFT.
REQ-018 Each channel's o_async_resetn and o_sync_resetn SHALL deassert on the same clock edge, OUT_LAT = META_STAGES+PIPE_STAGES cycles after its release-vector bit sets.
REQ-019 o_async_resetn SHALL drop to 0 within propagation delay of i_async_reset rising, with no clock required.
REQ-020 o_sync_resetn SHALL go to 0 only on clock edges, within OUT_LAT+1 cycles of i_async_reset rising; no flop in its path has an asynchronous reset.
REQ-021 RUN: i_soft_reset_req=1 moves FSM to SOFT; release vector clears next cycle; all channels assert (both outputs, synchronously) OUT_LAT cycles later.
REQ-022 SOFT: counter counts MIN_ASSERT_CYCLES, then enters RELEASE; o_soft_reset_ack pulses for one cycle on the next RELEASE->RUN transition.
REQ-023 i_soft_reset_req in HOLD, RELEASE or SOFT SHALL be ignored and produce no ack.
REQ-024 o_reset_done SHALL equal AND of o_sync_resetn, registered; 0 from any reset until last channel deasserts.
REQ-025 i_async_reset asserted mid-RELEASE or mid-SOFT SHALL abort the sequence, clear any pending ack, and restart from HOLD.
REQ-026 NUM_CHANNELS=1: RELEASE lasts one cycle; RELEASE_GAP unused.
REQ-027 Counter width SHALL be $clog2(max(MIN_ASSERT_CYCLES, RELEASE_GAP)+1); no wrap occurs.

Reset
REQ-028 While i_async_reset=1: o_async_resetn=0, o_reset_done=0, o_soft_reset_ack=0, FSM=HOLD, counters=0, release vector=0.
REQ-029 o_sync_resetn SHALL read 0 within OUT_LAT+1 cycles of reset assertion and remain 0 until REQ-018 releases it.

Structure
REQ-030 Package dla_reset_seq_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-031 Sub-module dla_reset_align_lane SHALL implement one channel: META_STAGES non-reset synchronizer plus PIPE_STAGES for sync output, matching-depth async-cleared shift for async output; instantiated NUM_CHANNELS times.
REQ-032 Internal reset synchronizer flops SHALL carry a fixed instance name for SDC wildcard constraints.

Verification
REQ-033 Defaults, i_async_reset 1->0 -> o_*_resetn[0] deasserts at edge 24 (+/-1), channel k at 24+8k, o_reset_done high one cycle after channel 3.
REQ-034 Each channel, every release -> o_async_resetn and o_sync_resetn deassert on identical edge.
REQ-035 Clock stopped, i_async_reset pulsed -> o_async_resetn=0 immediately; o_sync_resetn unchanged until clock resumes, then 0 within 6 cycles.
REQ-036 RUN, one-cycle i_soft_reset_req -> all channels assert 5 cycles later, re-release in order, single o_soft_reset_ack on completion.
REQ-037 i_async_reset asserted while channel 1 released, channel 2 pending -> all outputs to reset, no ack, full sequence restarts.
REQ-038 i_soft_reset_req during RELEASE -> ignored, sequence timing unchanged, no ack.

Source files
------------

// File: rtl/dla_reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   - seq_state_e : sequencer FSM states
//   - DEF_*       : default parameter values used by dla_reset_sequencer
//   - max_int     : helper for constant width calculations
package dla_reset_seq_pkg;

  localparam int DEF_NUM_CHANNELS      = 4;
  localparam int DEF_META_STAGES       = 3;
  localparam int DEF_PIPE_STAGES       = 2;
  localparam int DEF_MIN_ASSERT_CYCLES = 16;
  localparam int DEF_RELEASE_GAP       = 8;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dla_reset_align_lane.sv
// One reset channel: turns a release request into two aligned active-low
// resets.
//   clk            : clock
//   i_arst         : async clear of the async-output shift (active-high)
//   i_release      : release request from the sequencer (1 = release)
//   o_async_resetn : async assert, sync deassert
//   o_sync_resetn  : sync assert, sync deassert
// Both paths have the same depth and the same input, so they deassert on
// the same edge. The sync path has no reset at all: it asserts when zeros
// from the cleared release vector reach its end.
module dla_reset_align_lane #(
  parameter int META_STAGES = 3,
  parameter int PIPE_STAGES = 2
) (
  input  logic clk,
  input  logic i_arst,
  input  logic i_release,
  output logic o_async_resetn,
  output logic o_sync_resetn
);

  localparam int DEPTH = META_STAGES + PIPE_STAGES;

  // Bits [META_STAGES-1:0] form the synchronizer, the rest is retiming.
  logic [DEPTH-1:0] r_sync_sh;
  logic [DEPTH-1:0] r_async_sh;

  always_ff @(posedge clk) begin
    r_sync_sh <= {r_sync_sh[DEPTH-2:0], i_release};
  end

  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      r_async_sh <= '0;
    end else begin
      r_async_sh <= {r_async_sh[DEPTH-2:0], i_release};
    end
  end

  assign o_sync_resetn  = r_sync_sh[DEPTH-1];
  assign o_async_resetn = r_async_sh[DEPTH-1];

endmodule

// File: rtl/dla_reset_sequencer.sv
// Staged reset sequencer for NUM_CHANNELS reset domains.
//   clk              : clock
//   i_async_reset    : asynchronous active-high reset
//   i_soft_reset_req : single-cycle soft-reset request (honoured in RUN only)
//   o_soft_reset_ack : one-cycle pulse when a soft-reset sequence completes
//   o_async_resetn   : per channel, async assert / sync deassert
//   o_sync_resetn    : per channel, sync assert / sync deassert
//   o_reset_done     : high when every channel is released
// Channels are released one at a time in ascending order, RELEASE_GAP cycles
// apart, after all have been held for MIN_ASSERT_CYCLES.
module dla_reset_sequencer
  import dla_reset_seq_pkg::*;
#(
  parameter int NUM_CHANNELS      = DEF_NUM_CHANNELS,
  parameter int META_STAGES       = DEF_META_STAGES,
  parameter int PIPE_STAGES       = DEF_PIPE_STAGES,
  parameter int MIN_ASSERT_CYCLES = DEF_MIN_ASSERT_CYCLES,
  parameter int RELEASE_GAP       = DEF_RELEASE_GAP
) (
  input  logic                    clk,
  input  logic                    i_async_reset,
  input  logic                    i_soft_reset_req,
  output logic                    o_soft_reset_ack,
  output logic [NUM_CHANNELS-1:0] o_async_resetn,
  output logic [NUM_CHANNELS-1:0] o_sync_resetn,
  output logic                    o_reset_done
);

  localparam int CNT_W = $clog2(max_int(MIN_ASSERT_CYCLES, RELEASE_GAP) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
  localparam logic [NUM_CHANNELS-1:0] CH0_BIT = NUM_CHANNELS'(1);

  // Internal reset synchronizer. The register name r_int_rst_sync is kept
  // stable so timing constraints can match it with a wildcard.
  logic [META_STAGES-1:0] r_int_rst_sync;
  logic                   r_int_reset;

  always_ff @(posedge clk or posedge i_async_reset) begin
    if (i_async_reset) begin
      r_int_rst_sync <= '1;
    end else begin
      r_int_rst_sync <= {r_int_rst_sync[META_STAGES-2:0], 1'b0};
    end
  end

  assign r_int_reset = r_int_rst_sync[META_STAGES-1];

  seq_state_e              r_state;
  seq_state_e              w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  // Thermometer code: channels are released in ascending order, so bit k
  // set implies bits below k are set; the top bit marks the last release.
  logic [NUM_CHANNELS-1:0] r_rel;
  logic [NUM_CHANNELS-1:0] w_rel_nxt;
  logic                    r_soft_pend;
  logic                    w_soft_pend_nxt;
  logic                    r_ack;
  logic                    w_ack_nxt;
  logic                    r_reset_done;
  logic                    w_done_nxt;
  logic [NUM_CHANNELS-1:0] w_async_resetn;
  logic [NUM_CHANNELS-1:0] w_sync_resetn;

  always_ff @(posedge clk or posedge r_int_reset) begin
    if (r_int_reset) begin
      r_state      <= ST_HOLD;
      r_cnt        <= '0;
      r_rel        <= '0;
      r_soft_pend  <= 1'b0;
      r_ack        <= 1'b0;
      r_reset_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rel        <= w_rel_nxt;
      r_soft_pend  <= w_soft_pend_nxt;
      r_ack        <= w_ack_nxt;
      r_reset_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rel_nxt       = r_rel;
    w_soft_pend_nxt = r_soft_pend;
    w_ack_nxt       = 1'b0;
    unique case (r_state)
      ST_HOLD, ST_SOFT: begin
        w_rel_nxt = '0;
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RELEASE;
          w_cnt_nxt   = '0;
          w_rel_nxt   = CH0_BIT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (r_rel[NUM_CHANNELS-1]) begin
          w_state_nxt     = ST_RUN;
          w_cnt_nxt       = '0;
          w_ack_nxt       = r_soft_pend;
          w_soft_pend_nxt = 1'b0;
        end else if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          w_rel_nxt = (r_rel << 1) | CH0_BIT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (i_soft_reset_req) begin
          w_state_nxt     = ST_SOFT;
          w_cnt_nxt       = '0;
          w_rel_nxt       = '0;
          w_soft_pend_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = '0;
        w_rel_nxt   = '0;
      end
    endcase
  end

  // After an async reset the sync outputs may still be flushing while the
  // FSM restarts, so done is only allowed once the release vector is full.
  // In SOFT the vector is already clear but the outputs are still released
  // until the zeros reach them.
  always_comb begin
    w_done_nxt = (&w_sync_resetn) & ((r_state == ST_SOFT) | (&r_rel));
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
    dla_reset_align_lane #(
      .META_STAGES (META_STAGES),
      .PIPE_STAGES (PIPE_STAGES)
    ) u_lane (
      .clk            (clk),
      .i_arst         (r_int_reset),
      .i_release      (r_rel[k]),
      .o_async_resetn (w_async_resetn[k]),
      .o_sync_resetn  (w_sync_resetn[k])
    );
  end

  assign o_async_resetn   = w_async_resetn;
  assign o_sync_resetn    = w_sync_resetn;
  assign o_soft_reset_ack = r_ack;
  assign o_reset_done     = r_reset_done;

endmodule
